// File: rtl/freq_ctrl_pkg.sv
// Shared definitions for the frequency-select controller: FSM encoding,
// index/code widths, the reset period code and the minimum period.
package freq_ctrl_pkg;

    localparam int IDX_W  = 3;
    localparam int CODE_W = 8;

    localparam logic [CODE_W-1:0] RESET_CODE = 8'd30;
    localparam logic [CODE_W-1:0] MIN_PERIOD = 8'd2;
    localparam logic [IDX_W-1:0]  IDX_MAX    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_CAPTURE,
        ST_ARMED
    } state_t;

    // Codes below the minimum period are stretched to the minimum.
    function automatic logic [CODE_W-1:0] effPeriod(input logic [CODE_W-1:0] code);
        return (code < MIN_PERIOD) ? MIN_PERIOD : code;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: the output level follows the raw input only after
// DEBOUNCE_CYCLES consecutive samples that differ from the current level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic CLK,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    // Count disagreeing samples; flip the level on the last one, restart on agreement.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (raw != level_q) begin
            if (cnt_q == LAST) begin
                level_d = raw;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/freq_select_ctrl.sv
// Frequency-select controller: debounced up/down buttons step a saturating
// 3-bit index into the lookup memory; the returned period code is applied to
// the period counter only at a period boundary.
// Optional feature macro: FREQ_SWEEP_EN (adds sweep_en and auto-stepping).
module freq_select_ctrl
    import freq_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SWEEP_PERIODS   = 4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic [CODE_W-1:0] freq_code,
`ifdef FREQ_SWEEP_EN
    input  logic              sweep_en,
`endif
    output logic [IDX_W-1:0]  num_frecuencia,
    output logic [CODE_W-1:0] period_code,
    output logic              period_tick,
    output logic              busy,
    output logic              update_done
);

    logic upLevel, downLevel;
    logic upPrev_q, downPrev_q;
    logic upReq, downReq;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic              lookCnt_q, lookCnt_d;
    logic [CODE_W-1:0] pending_q, pending_d;
    logic [CODE_W-1:0] periodCode_q, periodCode_d;
    logic [CODE_W-1:0] count_q, count_d;
    logic              updateDone_q, updateDone_d;

    logic              periodTick;
    logic              stepValid;
    logic [IDX_W-1:0]  stepIndex;
    logic              sweepFire;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .CLK   (CLK),
        .reset (reset),
        .raw   (btn_up),
        .level (upLevel)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
        .CLK   (CLK),
        .reset (reset),
        .raw   (btn_down),
        .level (downLevel)
    );

    assign upReq      = upLevel & ~upPrev_q;
    assign downReq    = downLevel & ~downPrev_q;
    assign periodTick = (count_q == (effPeriod(periodCode_q) - 8'd1));

`ifdef FREQ_SWEEP_EN
    localparam int SW = $clog2(SWEEP_PERIODS + 1);
    localparam logic [SW-1:0] SWEEP_LAST = SW'(SWEEP_PERIODS - 1);

    logic [SW-1:0] sweepCnt_q, sweepCnt_d;

    assign sweepFire = sweep_en && (state_q == ST_IDLE) && periodTick
                       && (sweepCnt_q == SWEEP_LAST);

    // Count period ticks spent idle with sweeping enabled; restart after each sweep step.
    always_comb begin
        sweepCnt_d = sweepCnt_q;
        if (!sweep_en) begin
            sweepCnt_d = '0;
        end else if ((state_q == ST_IDLE) && periodTick) begin
            sweepCnt_d = (sweepCnt_q == SWEEP_LAST) ? '0 : sweepCnt_q + 1'b1;
        end
    end

    // Sweep period counter register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            sweepCnt_q <= '0;
        end else begin
            sweepCnt_q <= sweepCnt_d;
        end
    end
`else
    // SWEEP_PERIODS only matters to the sweep build; this sink keeps it referenced.
    logic [7:0] sweepUnused;
    assign sweepUnused = 8'(SWEEP_PERIODS);
    assign sweepFire   = 1'b0;
`endif

    // Resolve button/sweep requests into one step; conflicting or saturated buttons are dropped.
    always_comb begin
        stepValid = 1'b0;
        stepIndex = index_q;
        if (upReq || downReq) begin
            if (upReq && !downReq && (index_q != IDX_MAX)) begin
                stepValid = 1'b1;
                stepIndex = index_q + 3'd1;
            end else if (downReq && !upReq && (index_q != '0)) begin
                stepValid = 1'b1;
                stepIndex = index_q - 3'd1;
            end
        end else if (sweepFire) begin
            stepValid = 1'b1;
            stepIndex = index_q + 3'd1;
        end
    end

    // Update FSM next state, index, pending code and applied code.
    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        lookCnt_d    = 1'b0;
        pending_d    = pending_q;
        periodCode_d = periodCode_q;
        updateDone_d = 1'b0;
        count_d      = periodTick ? '0 : count_q + 8'd1;
        case (state_q)
            ST_IDLE: begin
                if (stepValid) begin
                    state_d = ST_LOOKUP;
                    index_d = stepIndex;
                end
            end
            ST_LOOKUP: begin
                if (lookCnt_q) begin
                    state_d = ST_CAPTURE;
                end else begin
                    lookCnt_d = 1'b1;
                end
            end
            ST_CAPTURE: begin
                pending_d = freq_code;
                state_d   = ST_ARMED;
            end
            ST_ARMED: begin
                if (periodTick) begin
                    periodCode_d = pending_q;
                    count_d      = '0;
                    updateDone_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            index_q      <= '0;
            lookCnt_q    <= 1'b0;
            pending_q    <= RESET_CODE;
            periodCode_q <= RESET_CODE;
            count_q      <= '0;
            updateDone_q <= 1'b0;
            upPrev_q     <= 1'b0;
            downPrev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            lookCnt_q    <= lookCnt_d;
            pending_q    <= pending_d;
            periodCode_q <= periodCode_d;
            count_q      <= count_d;
            updateDone_q <= updateDone_d;
            upPrev_q     <= upLevel;
            downPrev_q   <= downLevel;
        end
    end

    assign num_frecuencia = index_q;
    assign period_code    = periodCode_q;
    assign period_tick    = periodTick;
    assign busy           = (state_q != ST_IDLE);
    assign update_done    = updateDone_q;

endmodule

// File: tb/tb_freq_select_ctrl.sv
// Directed testbench for freq_select_ctrl with a registered lookup-memory model.
module tb_freq_select_ctrl;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [7:0] freq_code = 8'd0;
`ifdef FREQ_SWEEP_EN
    logic       sweep_en = 1'b0;
`endif
    logic [2:0] num_frecuencia;
    logic [7:0] period_code;
    logic       period_tick;
    logic       busy;
    logic       update_done;

    int checks   = 0;
    int failures = 0;
    int updCount = 0;
    int busySeen = 0;

    freq_select_ctrl #(.DEBOUNCE_CYCLES(16), .SWEEP_PERIODS(4)) dut (
        .CLK            (CLK),
        .reset          (reset),
        .btn_up         (btn_up),
        .btn_down       (btn_down),
        .freq_code      (freq_code),
`ifdef FREQ_SWEEP_EN
        .sweep_en       (sweep_en),
`endif
        .num_frecuencia (num_frecuencia),
        .period_code    (period_code),
        .period_tick    (period_tick),
        .busy           (busy),
        .update_done    (update_done)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] romValue(input logic [2:0] idx);
        case (idx)
            3'd0: return 8'd30;
            3'd1: return 8'd50;
            3'd2: return 8'd75;
            3'd3: return 8'd100;
            3'd4: return 8'd125;
            3'd5: return 8'd150;
            3'd6: return 8'd175;
            default: return 8'd200;
        endcase
    endfunction

    // Lookup memory model: one cycle of registered latency.
    always @(posedge CLK) freq_code <= romValue(num_frecuencia);

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge CLK);
        #1;
        updCount += int'(update_done);
        if (busy) busySeen = 1;
    endtask

    task automatic clearTrack();
        updCount = 0;
        busySeen = 0;
    endtask

    task automatic resetDut();
        reset    = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (3) stepCycle();
        reset = 1'b0;
    endtask

    task automatic waitTick(input string tag, input int limit);
        int n = 0;
        while (!period_tick && n < limit) begin
            stepCycle();
            n++;
        end
        if (!period_tick) checkOutput(tag, period_tick, 1);
    endtask

    task automatic waitUpdate(input string tag, input int limit);
        int n = 0;
        while (!update_done && n < limit) begin
            stepCycle();
            n++;
        end
        checkOutput(tag, update_done, 1);
    endtask

    task automatic measurePeriod(input string tag, input int expected);
        int n = 0;
        waitTick({tag, " first tick"}, 300);
        do begin
            stepCycle();
            n++;
        end while (!period_tick && n < 300);
        checkOutput(tag, n, expected);
    endtask

    // Hold the buttons, release, let any update finish and the debouncers drop.
    task automatic applyStimulus(input string tag, input logic up, input logic down, input int hold);
        int n = 0;
        clearTrack();
        btn_up   = up;
        btn_down = down;
        repeat (hold) stepCycle();
        btn_up   = 1'b0;
        btn_down = 1'b0;
        while (busy && n < 600) begin
            stepCycle();
            n++;
        end
        checkOutput({tag, " idle"}, busy, 0);
        repeat (20) stepCycle();
    endtask

    initial begin
        // Reset state and default period
        resetDut();
        checkOutput("rst index", num_frecuencia, 0);
        checkOutput("rst period_code", period_code, 30);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst update_done", update_done, 0);
        checkOutput("rst period_tick", period_tick, 0);
        measurePeriod("rst period len", 30);

        // Held press: index moves on edge 17, code 50 applied at a tick
        resetDut();
        btn_up = 1'b1;
        repeat (16) stepCycle();
        checkOutput("hold idx before 17", num_frecuencia, 0);
        stepCycle();
        checkOutput("hold idx at 17", num_frecuencia, 1);
        checkOutput("hold busy at 17", busy, 1);
        repeat (3) stepCycle();
        btn_up = 1'b0;
        waitUpdate("hold update_done", 300);
        checkOutput("hold period_code", period_code, 50);
        checkOutput("hold busy after", busy, 0);
        checkOutput("hold index after", num_frecuencia, 1);
        measurePeriod("hold period len", 50);

        // Bouncing press gives exactly one step
        resetDut();
        clearTrack();
        btn_up = 1'b1; repeat (5) stepCycle();
        btn_up = 1'b0; repeat (3) stepCycle();
        btn_up = 1'b1; repeat (20) stepCycle();
        btn_up = 1'b0;
        repeat (120) stepCycle();
        checkOutput("bounce updates", updCount, 1);
        checkOutput("bounce index", num_frecuencia, 1);
        checkOutput("bounce period_code", period_code, 50);

        // Down at index 0 is saturated
        resetDut();
        applyStimulus("down@0", 1'b0, 1'b1, 20);
        checkOutput("down@0 index", num_frecuencia, 0);
        checkOutput("down@0 busy seen", busySeen, 0);
        checkOutput("down@0 updates", updCount, 0);
        checkOutput("down@0 period_code", period_code, 30);

        // Climb to index 7
        for (int i = 1; i <= 7; i++) begin
            applyStimulus("climb", 1'b1, 1'b0, 20);
            checkOutput("climb index", num_frecuencia, i);
            checkOutput("climb updates", updCount, 1);
        end
        checkOutput("climb period_code", period_code, 200);

        // Up at index 7 is saturated; simultaneous up+down is dropped
        applyStimulus("up@7", 1'b1, 1'b0, 20);
        checkOutput("up@7 index", num_frecuencia, 7);
        checkOutput("up@7 busy seen", busySeen, 0);
        checkOutput("up@7 period_code", period_code, 200);
        applyStimulus("both", 1'b1, 1'b1, 20);
        checkOutput("both index", num_frecuencia, 7);
        checkOutput("both busy seen", busySeen, 0);

        // Up press while ARMED (long 200 period) is dropped
        waitTick("armed align", 300);
        clearTrack();
        btn_down = 1'b1; repeat (20) stepCycle();
        btn_down = 1'b0; repeat (20) stepCycle();
        checkOutput("armed busy", busy, 1);
        btn_up = 1'b1; repeat (20) stepCycle();
        btn_up = 1'b0;
        checkOutput("armed index", num_frecuencia, 6);
        checkOutput("armed still busy", busy, 1);
        waitUpdate("armed update_done", 300);
        checkOutput("armed period_code", period_code, 175);
        repeat (40) stepCycle();
        checkOutput("armed index after", num_frecuencia, 6);
        checkOutput("armed busy after", busy, 0);
        checkOutput("armed updates", updCount, 1);

        // Reset while ARMED discards the pending code
        waitTick("rstarm align", 300);
        btn_up = 1'b1;
        repeat (25) stepCycle();
        checkOutput("rstarm busy before", busy, 1);
        btn_up = 1'b0;
        reset  = 1'b1;
        repeat (2) stepCycle();
        reset = 1'b0;
        checkOutput("rstarm period_code", period_code, 30);
        checkOutput("rstarm index", num_frecuencia, 0);
        checkOutput("rstarm busy", busy, 0);
        checkOutput("rstarm update_done", update_done, 0);
        clearTrack();
        repeat (300) stepCycle();
        checkOutput("rstarm no update", updCount, 0);
        checkOutput("rstarm period_code later", period_code, 30);

`ifdef FREQ_SWEEP_EN
        // Sweep steps 1..7 then wraps to 0, codes follow the table
        resetDut();
        sweep_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            waitUpdate("sweep update_done", 1200);
            checkOutput("sweep index", num_frecuencia, k % 8);
            checkOutput("sweep period_code", period_code, romValue(3'(k % 8)));
            stepCycle();
        end
        sweep_en = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
